// File: rtl/dff_lc_pipe.sv
// ---------------------------------------------------------------------------
// dff_lc_pipe
// Stallable multi-stage level-conversion register pipeline. It carries signed
// DCT coefficient words across a voltage-domain boundary and has a
// valid/ready handshake, bubble collapsing, flush and an occupancy count.
//
// Parameters:
//   WIDTH  data word width in bits (signed), >= 1
//   DEPTH  number of register stages, >= 1
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst          synchronous, active-high reset (overrides wr_en and flush)
//   wr_en        global enable; low freezes all state
//   flush        synchronous clear of every valid bit (only when wr_en=1)
//   in_valid     upstream word valid
//   in_ready     pipeline can accept a word this cycle (combinational)
//   in_data      signed input word
//   out_valid    word available at the last stage (combinational)
//   out_ready    downstream accepts the word
//   out_data     signed word held in stage DEPTH-1
//   count        number of occupied stages (0..DEPTH)
//   out_par_err  stored parity disagrees with the word leaving (combinational)
//
// Build option:
//   LC_PIPE_PARITY_EN  when defined, each stage also stores the even parity of
//                      its word, and out_par_err reports a mismatch at the
//                      output. When undefined, out_par_err is tied to 0.
// ---------------------------------------------------------------------------
module dff_lc_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic [CW-1:0]           count,
  output logic                    out_par_err
);

  // Per-stage state: valid bit and data word. Stage 0 is the input side.
  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;

`ifdef LC_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q, par_d;
`endif

  // Handshake terms
  logic             active_c;
  logic             pop_c;
  logic             push_c;
  logic [DEPTH-1:0] free_c;

  // The pipe only moves when enabled and not being flushed.
  assign active_c  = wr_en & ~flush;
  assign out_valid = v_q[DEPTH-1] & active_c;
  assign pop_c     = out_valid & out_ready;
  assign in_ready  = free_c[0] & active_c;
  assign push_c    = in_valid & in_ready;
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;

  // A stage is free when it is empty or everything downstream of it can move.
  // This collapses bubbles. A running variable avoids a self-referencing vector.
  always_comb begin
    logic f;
    free_c = '0;
    f = ~v_q[DEPTH-1] | pop_c;
    free_c[DEPTH-1] = f;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      f = ~v_q[i] | f;
      free_c[i] = f;
    end
  end

  // Next-state: shift into free stages. Data only loads behind a valid bit.
  always_comb begin
    v_d     = v_q;
    d_d     = d_q;
    count_d = count_q;
`ifdef LC_PIPE_PARITY_EN
    par_d   = par_q;
`endif
    if (active_c) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (free_c[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) begin
            d_d[i] = d_q[i-1];
`ifdef LC_PIPE_PARITY_EN
            par_d[i] = par_q[i-1];
`endif
          end
        end
      end
      if (free_c[0]) begin
        v_d[0] = push_c;
        if (push_c) begin
          d_d[0] = in_data;
`ifdef LC_PIPE_PARITY_EN
          par_d[0] = ^in_data;
`endif
        end
      end
      // Push and pop together leave the occupancy unchanged.
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end else if (wr_en && flush) begin
      // Flush drops every word but leaves the data registers untouched.
      v_d     = '0;
      count_d = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
`ifdef LC_PIPE_PARITY_EN
      par_q   <= '0;
`endif
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      d_q     <= d_d;
`ifdef LC_PIPE_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

`ifdef LC_PIPE_PARITY_EN
  // Flag a word whose recomputed parity disagrees with the parity stored for it.
  assign out_par_err = out_valid & ((^d_q[DEPTH-1]) != par_q[DEPTH-1]);
`else
  assign out_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_dff_lc_pipe.sv
// Self-checking bench for dff_lc_pipe (WIDTH=8, DEPTH=4). It uses a per-cycle
// vector table for the reset/latency case and a word-position queue model for
// the streaming, backpressure, freeze and flush cases.
module tb_dff_lc_pipe;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst, wr_en, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
  logic [CW-1:0]    count;
  logic             out_par_err;

  int total = 0;
  int bad   = 0;

  dff_lc_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .out_par_err(out_par_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: words in flight in order, front = oldest, each with its stage index.
  typedef struct {
    logic [WIDTH-1:0] d;
    int               pos;
  } ent_t;
  ent_t mq[$];

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mq = {};
  endtask

  // One model-checked clock cycle with the given inputs.
  task automatic cyc(input logic w, input logic f, input logic iv,
                     input logic [WIDTH-1:0] din, input logic ordy);
    bit   act, ov_e, pop_e, ir_e;
    int   lim, np;
    ent_t e;
    ent_t nq[$];
    wr_en = w; flush = f; in_valid = iv; in_data = din; out_ready = ordy;
    @(negedge clk);
    act   = w && !f;
    ov_e  = act && (mq.size() > 0) && (mq[0].pos == int'(DEPTH) - 1);
    pop_e = ov_e && ordy;
    // Each remaining word advances one stage unless blocked by the word ahead.
    nq  = {};
    lim = int'(DEPTH) - 1;
    foreach (mq[k]) begin
      if (k == 0 && pop_e) continue;
      e   = mq[k];
      np  = (e.pos + 1 < lim) ? e.pos + 1 : lim;
      e.pos = np;
      lim = np - 1;
      nq.push_back(e);
    end
    ir_e = act && ((nq.size() == 0) || (nq[nq.size()-1].pos > 0));
    chk("out_valid", 32'(out_valid), 32'(ov_e));
    chk("in_ready",  32'(in_ready),  32'(ir_e));
    chk("count",     32'(count),     32'(mq.size()));
    chk("par_err",   32'(out_par_err), 32'(0));
    if (ov_e) chk("out_data", 32'(out_data), 32'(mq[0].d));
    @(posedge clk); #1;
    if (act) begin
      mq = nq;
      if (iv && ir_e) mq.push_back('{din, 0});
    end else if (w && f) begin
      mq = {};
    end
  endtask

  typedef struct {
    logic             rst, wr, fl, iv;
    logic [WIDTH-1:0] din;
    logic             ordy;
    logic             ov;
    logic [WIDTH-1:0] od;
    logic             ir;
    logic [CW-1:0]    cnt;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int lat;
    // Reset then one push of -5 into an empty pipe (pushed at the row-2 edge).
    //          rst   wr    fl    iv    din    ordy  ov    od     ir    cnt
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hFB, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 3'd1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 3'd1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 3'd1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFB, 1'b1, 3'd1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFB, 1'b1, 3'd0};

    // Two reset edges bring the state to a known value before the table.
    rst = 1'b1; wr_en = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      rst = tbl[i].rst; wr_en = tbl[i].wr; flush = tbl[i].fl;
      in_valid = tbl[i].iv; in_data = tbl[i].din; out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_out_data", i),  32'(out_data),  32'(tbl[i].od));
      chk($sformatf("tbl%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].ir));
      chk($sformatf("tbl%0d_count", i),     32'(count),     32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_par_err", i),   32'(out_par_err), 32'(0));
      @(posedge clk); #1;
    end

    // Streaming 0..15 at full rate, then drain.
    do_reset();
    for (int k = 0; k < 16; k++) cyc(1'b1, 1'b0, 1'b1, WIDTH'(k), 1'b1);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Backpressure with bubbles: 1,_,2,_,3,4 then 5 held until space opens.
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 8'd1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'd2, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'd3, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'd4, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'd5, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'd5, 1'b0);
    @(negedge clk);
    chk("bp_full_count", 32'(count), 32'(DEPTH));
    chk("bp_full_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk); #1;
    cyc(1'b1, 1'b0, 1'b1, 8'd5, 1'b1);
    repeat (6) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("bp_drained", 32'(mq.size()), 32'(0));

    // wr_en freeze with three words held.
    do_reset();
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b1, 8'hA0 + WIDTH'(k), 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1);
    repeat (6) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Flush of a full pipe while pushing, then a fresh push of 0x7F.
    do_reset();
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b1, 8'hC0 + WIDTH'(k), 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h55, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 8'h7F, 1'b1);
    wr_en = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
      lat++;
    end
    chk("flush_latency", 32'(lat), 32'(DEPTH - 1));
    chk("flush_word", 32'(out_data), 32'(8'h7F));
    chk("flush_count", 32'(count), 32'(1));

`ifdef LC_PIPE_PARITY_EN
    // Corrupt the parity stored with the word in the last stage.
    begin
      logic [DEPTH-1:0] pv;
      pv = dut.par_q;
      force dut.par_q = pv ^ DEPTH'(1 << (DEPTH - 1));
      #1;
      chk("par_err_set", 32'(out_par_err), 32'(1));
      wr_en = 1'b0;
      #1;
      chk("par_err_frozen", 32'(out_par_err), 32'(0));
      wr_en = 1'b1;
      @(posedge clk); #1;
      release dut.par_q;
      @(negedge clk);
      chk("par_err_held", 32'(out_par_err), 32'(1));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("par_err_gone", 32'(out_par_err), 32'(0));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
